dma_fifo_drain: RTL and testbench

Read-side engine of the DMA controller's asynchronous FIFO. It runs entirely in the read clock domain and owns the read pointer. It drains words from the 8-entry, 32-bit first-word-fall-through FIFO memory and presents each word, with an incrementing destination address, to a downstream write port over a valid/ready handshake until a programmed word count is met. It is the consumer counterpart to the FIFO write side.

---
 rtl/dma_pkg.sv | 19 +
 rtl/fifo_rptr_empty.sv | 32 +++
 rtl/dma_fifo_drain.sv | 100 ++++++++++
 tb/tb_dma_fifo_drain.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA FIFO read-side engine.
package dma_pkg;

  localparam int DEPTH      = 8;
  localparam int PTR_W      = $clog2(DEPTH) + 1;  // index bits plus wrap bit
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_rptr_empty.sv
// Read pointer (binary and Gray) and the empty compare against the
// write pointer that has already been synchronized into the read domain.
module fifo_rptr_empty
  import dma_pkg::*;
(
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] wptr_gray,
  output logic [PTR_W-1:0] bin_ptr,
  output logic [PTR_W-1:0] gray_ptr,
  output logic             empty
);

  logic [PTR_W-1:0] bin_nxt;

  assign bin_nxt = bin_ptr + PTR_W'(1);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
    end else if (rd_en) begin
      bin_ptr  <= bin_nxt;
      gray_ptr <= bin2gray(bin_nxt);
    end
  end

  // Synchronizer lag on wptr_gray makes this compare conservative.
  assign empty = (gray_ptr == wptr_gray);

endmodule

// File: rtl/dma_fifo_drain.sv
// DMA read-side engine: drains the FWFT FIFO and writes each word to an
// incrementing destination address over a valid/ready port.
module dma_fifo_drain #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int PTR_W  = dma_pkg::PTR_W
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  input  logic [PTR_W-1:0]  rq_wptr_gray,
  output logic [PTR_W-1:0]  rd_ptr_gray,
  output logic              fifo_empty,
  output logic              rd_enable_fifo,
  output logic [PTR_W-1:0]  b_rd_ptr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  dma_pkg::state_t   state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              last_word;
  logic              load;

  fifo_rptr_empty u_rptr (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rd_en     (rd_enable_fifo),
    .wptr_gray (rq_wptr_gray),
    .bin_ptr   (b_rd_ptr),
    .gray_ptr  (rd_ptr_gray),
    .empty     (fifo_empty)
  );

  assign accept    = (state == dma_pkg::SEND) && m_ready;
  assign last_word = (remaining == LEN_W'(1));
  assign load      = (state == dma_pkg::IDLE) && start && (xfer_len != '0);

  always_comb begin
    state_nxt      = state;
    rd_enable_fifo = 1'b0;
    unique case (state)
      dma_pkg::IDLE: begin
        if (start) state_nxt = (xfer_len == '0) ? dma_pkg::DONE : dma_pkg::FETCH;
      end
      dma_pkg::FETCH: begin
        if (!fifo_empty) begin
          rd_enable_fifo = 1'b1;
          state_nxt      = dma_pkg::SEND;
        end
      end
      dma_pkg::SEND: begin
        // The final word never pulls another word out of the FIFO.
        if (m_ready) begin
          if (last_word)        state_nxt = dma_pkg::DONE;
          else if (!fifo_empty) rd_enable_fifo = 1'b1;
          else                  state_nxt = dma_pkg::FETCH;
        end
      end
      dma_pkg::DONE: state_nxt = dma_pkg::IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= dma_pkg::IDLE;
      addr_q    <= '0;
      remaining <= '0;
      data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        addr_q    <= dst_addr;
        remaining <= xfer_len;
      end else if (accept) begin
        addr_q    <= addr_q + ADDR_W'(dma_pkg::WORD_BYTES);
        remaining <= remaining - LEN_W'(1);
      end
      if (rd_enable_fifo) data_q <= rd_data;
    end
  end

  assign busy    = (state != dma_pkg::IDLE);
  assign done    = (state == dma_pkg::DONE);
  assign m_valid = (state == dma_pkg::SEND);
  assign m_addr  = addr_q;
  assign m_data  = data_q;

endmodule

// File: tb/tb_dma_fifo_drain.sv
// Bench for dma_fifo_drain: FIFO write-side model, queue-based reference
// model checked on every falling edge, directed cases plus a random phase.
module tb_dma_fifo_drain;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] xfer_len = '0;
  logic        busy, done;
  logic [3:0]  rq_wptr_gray = '0;
  logic [3:0]  rd_ptr_gray, b_rd_ptr;
  logic        fifo_empty, rd_enable_fifo;
  logic [31:0] rd_data;
  logic        m_valid;
  logic [31:0] m_addr, m_data;
  logic        m_ready = 1'b0;

  logic [31:0] mem [0:7];
  assign rd_data = mem[b_rd_ptr[2:0]];

  dma_fifo_drain dut (
    .rclk(rclk), .rrst_n(rrst_n), .start(start), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .busy(busy), .done(done), .rq_wptr_gray(rq_wptr_gray),
    .rd_ptr_gray(rd_ptr_gray), .fifo_empty(fifo_empty),
    .rd_enable_fifo(rd_enable_fifo), .b_rd_ptr(b_rd_ptr), .rd_data(rd_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 rclk = ~rclk;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state (owned by the compare process)
  logic        active = 1'b0;
  logic        done_due = 1'b0;
  int          rem = 0;
  int          rcnt = 0;
  int          acc_total = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [31:0] addr_exp_q [$];
  logic [31:0] fifo_model [$];
  int          rd_log [$];
  int          done_log [$];
  int          acc_cyc [$];
  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];

  // write-side environment
  logic [31:0] wr_q [$];
  logic [3:0]  wbin = '0;
  logic [3:0]  sync1 = '0;
  int          gap_cnt = 0;
  int          wr_gap = 0;
  bit          rand_gap = 0;
  bit          rand_ready = 0;
  logic        ready_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge rclk) cyc++;

  // Write side: two-flop pointer synchronizer, paced writes, full guard.
  initial begin
    logic [3:0] occ;
    forever begin
      @(posedge rclk); #2;
      m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
      if (!rrst_n) begin
        wbin = '0; sync1 = '0; rq_wptr_gray = '0; gap_cnt = 0;
      end else begin
        rq_wptr_gray = sync1;
        sync1 = gray_tab[wbin];
        occ = wbin - rcnt[3:0];
        if (gap_cnt > 0) gap_cnt--;
        else if (wr_q.size() > 0 && occ < 4'd8) begin
          mem[wbin[2:0]] = wr_q.pop_front();
          wbin = wbin + 4'd1;
          gap_cnt = rand_gap ? $urandom_range(0, 4) : wr_gap;
        end
      end
    end
  end

  // Compare process: outputs against the queue model every cycle.
  always @(negedge rclk) begin
    logic was_active, nd, acc, emp_model;
    if (!rrst_n) begin
      active = 0; done_due = 0; rem = 0; rcnt = 0; acc_total = 0; prev_stall = 0;
      addr_exp_q.delete();
    end else begin
      was_active = active;
      nd = 1'b0;
      acc = m_valid && m_ready;
      emp_model = (gray_tab[rcnt[3:0]] == rq_wptr_gray);
      chk("busy", busy, active);
      chk("done", done, done_due);
      chk("valid_outside_xfer", m_valid && !active, 0);
      chk("b_rd_ptr", b_rd_ptr, rcnt[3:0]);
      chk("rd_ptr_gray", rd_ptr_gray, gray_tab[rcnt[3:0]]);
      chk("fifo_empty", fifo_empty, emp_model);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_addr", m_addr, prev_addr);
        chk("stall_data", m_data, prev_data);
      end
      if (rd_enable_fifo) begin
        chk("overread", emp_model, 0);
        chk("read_outside_xfer", active && !done_due, 1);
        chk("read_while_stalled", m_valid && !m_ready, 0);
        chk("read_on_last_word", m_valid && (rem == 1), 0);
        rd_log.push_back(cyc);
        rcnt++;
      end
      if (acc) begin
        if (addr_exp_q.size() == 0 || fifo_model.size() == 0) chk("unexpected_accept", acc, 0);
        else begin
          chk("m_addr", m_addr, addr_exp_q.pop_front());
          chk("m_data", m_data, fifo_model.pop_front());
        end
        acc_cyc.push_back(cyc); acc_addr.push_back(m_addr); acc_data.push_back(m_data);
        acc_total++;
        rem--;
        if (rem == 0) nd = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_addr = m_addr;
      prev_data = m_data;
      chk("read_ahead", rcnt <= acc_total + 1, 1);
      if (done_due) begin
        chk("done_read_count", rcnt, acc_total);
        done_log.push_back(cyc);
        active = 1'b0;
      end
      if (start && !was_active) begin
        active = 1'b1;
        if (xfer_len == 16'd0) nd = 1'b1;
        else begin
          rem = xfer_len;
          for (int i = 0; i < int'(xfer_len); i++) addr_exp_q.push_back(dst_addr + 32'(4 * i));
        end
      end
      done_due = nd;
    end
  end

  task automatic tick();
    @(posedge rclk); #1;
  endtask

  task automatic push(input logic [31:0] w);
    wr_q.push_back(w);
    fifo_model.push_back(w);
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] l, output int c);
    start = 1'b1; dst_addr = a; xfer_len = l; c = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit to = 1;
    for (int i = 0; i < budget; i++) begin
      if (!active) begin to = 0; break; end
      tick();
    end
    chk(name, to, 0);
  endtask

  task automatic wait_valid(input string name);
    bit to = 1;
    for (int i = 0; i < 50; i++) begin
      if (m_valid) begin to = 0; break; end
      tick();
    end
    chk(name, to, 0);
  endtask

  task automatic do_reset(input int hold);
    rrst_n = 1'b0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rd_en", rd_enable_fifo, 0);
    chk("rst_b_rd_ptr", b_rd_ptr, 0);
    chk("rst_rd_ptr_gray", rd_ptr_gray, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data", m_data, 0);
    wr_q.delete();
    fifo_model.delete();
    repeat (hold) @(posedge rclk);
    #1;
    chk("rst_fifo_empty", fifo_empty, 1);
    rrst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, na, nr, nd;
    bit to;
    logic [3:0] ptr_exp [3];
    logic [3:0] gray_exp [3];
    for (int i = 0; i < 8; i++) mem[i] = '0;
    tick();
    do_reset(3);

    // 1: pre-filled FIFO, back-to-back drain
    push(32'hA0); push(32'hA1); push(32'hA2);
    to = 1;
    for (int i = 0; i < 30; i++) begin
      if (rq_wptr_gray == 4'b0010) begin to = 0; break; end
      tick();
    end
    chk("t1_fill_timeout", to, 0);
    na = acc_addr.size(); nr = rd_log.size(); nd = done_log.size();
    do_start(32'h1000, 16'd3, c);
    wait_idle("t1_timeout", 50);
    chk("t1_addr0", acc_addr[na], 32'h1000);
    chk("t1_addr1", acc_addr[na+1], 32'h1004);
    chk("t1_addr2", acc_addr[na+2], 32'h1008);
    chk("t1_data0", acc_data[na], 32'hA0);
    chk("t1_data1", acc_data[na+1], 32'hA1);
    chk("t1_data2", acc_data[na+2], 32'hA2);
    chk("t1_first_read_cyc", rd_log[nr], c + 1);
    chk("t1_acc_cyc0", acc_cyc[na], c + 2);
    chk("t1_acc_cyc1", acc_cyc[na+1], c + 3);
    chk("t1_acc_cyc2", acc_cyc[na+2], c + 4);
    chk("t1_done_cyc", done_log[nd], c + 5);
    chk("t1_b_rd_ptr", b_rd_ptr, 3);
    chk("t1_gray", rd_ptr_gray, 4'b0010);

    // 2: start on empty FIFO, slow writer
    wr_gap = 4;
    na = acc_addr.size(); nr = rd_log.size();
    do_start(32'h2000, 16'd2, c);
    repeat (8) tick();
    chk("t2_no_read_while_empty", rd_log.size(), nr);
    push(32'hB0); push(32'hB1);
    wait_idle("t2_timeout", 100);
    chk("t2_addr0", acc_addr[na], 32'h2000);
    chk("t2_addr1", acc_addr[na+1], 32'h2004);
    chk("t2_data1", acc_data[na+1], 32'hB1);
    chk("t2_b_rd_ptr", b_rd_ptr, 5);
    wr_gap = 0;

    // 3: destination stalls 4 cycles on the first word
    ready_force = 1'b0;
    push(32'hC0); push(32'hC1);
    repeat (6) tick();
    na = acc_addr.size();
    do_start(32'h3000, 16'd2, c);
    wait_valid("t3_valid_timeout");
    repeat (4) tick();
    ready_force = 1'b1;
    wait_idle("t3_timeout", 50);
    chk("t3_acc_cyc0", acc_cyc[na], c + 6);
    chk("t3_count", acc_addr.size(), na + 2);
    chk("t3_data0", acc_data[na], 32'hC0);
    chk("t3_b_rd_ptr", b_rd_ptr, 7);

    // 4: three len-6 transfers wrap the pointer 15 -> 0
    tick();
    do_reset(2);
    ptr_exp = '{4'd6, 4'd12, 4'd2};
    gray_exp = '{4'b0101, 4'b1010, 4'b0011};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) push(32'hD000_0000 + 32'(16 * k + i));
      do_start(32'h4000 + 32'(k * 256), 16'd6, c);
      wait_idle("t4_timeout", 200);
      chk("t4_b_rd_ptr", b_rd_ptr, ptr_exp[k]);
      chk("t4_gray", rd_ptr_gray, gray_exp[k]);
    end

    // 5: zero length, then start while busy
    na = acc_addr.size(); nd = done_log.size();
    do_start(32'h5000, 16'd0, c);
    wait_idle("t5_timeout", 10);
    chk("t5_done_cyc", done_log[nd], c + 1);
    chk("t5_no_writes", acc_addr.size(), na);
    chk("t5_ptr_unchanged", b_rd_ptr, 2);
    do_start(32'h6000, 16'd2, c);
    repeat (3) tick();
    do_start(32'h7000, 16'd5, c2);
    push(32'hE0); push(32'hE1);
    wait_idle("t5b_timeout", 100);
    repeat (3) tick();
    chk("t5b_count", acc_addr.size(), na + 2);
    chk("t5b_addr0", acc_addr[na], 32'h6000);
    chk("t5b_addr1", acc_addr[na+1], 32'h6004);
    chk("t5b_b_rd_ptr", b_rd_ptr, 4);

    // 6: reset mid-SEND
    ready_force = 1'b0;
    push(32'hF0); push(32'hF1); push(32'hF2);
    repeat (6) tick();
    nd = done_log.size();
    do_start(32'h8000, 16'd3, c);
    wait_valid("t6_valid_timeout");
    tick(); #2;
    do_reset(2);
    ready_force = 1'b1;
    repeat (4) tick();
    chk("t6_no_done", done_log.size(), nd);
    na = acc_addr.size();
    push(32'h11); push(32'h22);
    repeat (6) tick();
    do_start(32'h40, 16'd2, c);
    wait_idle("t6_timeout", 50);
    chk("t6_addr0", acc_addr[na], 32'h40);
    chk("t6_data1", acc_data[na+1], 32'h22);
    chk("t6_b_rd_ptr", b_rd_ptr, 2);

    // random phase
    rand_ready = 1; rand_gap = 1;
    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      logic [31:0] a;
      l = (t % 9 == 8) ? 16'd0 : 16'($urandom_range(1, 12));
      a = (t % 5 == 0) ? 32'hFFFF_FFF0 : $urandom;
      for (int i = 0; i < int'(l); i++) push($urandom);
      repeat ($urandom_range(0, 3)) tick();
      do_start(a, l, c);
      if (t % 4 == 1) begin
        tick();
        do_start($urandom, 16'd0, c2);
      end
      wait_idle("rand_timeout", 2000);
    end
    rand_ready = 0;
    repeat (5) tick();
    chk("rand_all_consumed", fifo_model.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
